// File: rtl/integration_pkg.sv
// Shared AHB types and constants for the integration bench fabric:
// transfer/burst encodings, the default master count and the burst
// length helper used by the arbiters.
package integration_pkg;

   localparam int master_number = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_e;

   // Number of beats still to come after the NONSEQ of a fixed-length
   // burst; SINGLE and undefined-length INCR never hold the bus.
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      logic [4:0] beats;
      case (hburst)
         WRAP4,  INCR4:  beats = 5'd3;
         WRAP8,  INCR8:  beats = 5'd7;
         WRAP16, INCR16: beats = 5'd15;
         default:        beats = 5'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// after 'last', searching upward and wrapping. When only 'last' requests
// it is returned again; with no request the result parks on index 0.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          any_req
);

   int   cand;
   logic found;

   // Scan the N candidates starting just above 'last'; k == N lands on 'last'
   always_comb begin
      idx     = '0;
      any_req = |req;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last) + k) % N;
         if (!found && req[cand]) begin
            idx   = cand[IW-1:0];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter and master-side multiplexer. Grants the bus round-robin,
// holds it for fixed-length bursts and locked sequences, and presents the
// address-phase and data-phase owners' signals to the slave fabric.
module ahb_arbiter
   import integration_pkg::*;
#(
   parameter int MASTER_NUMBER = master_number
) (
   input  logic                       hclk,
   input  logic                       hreset,
   input  logic [MASTER_NUMBER-1:0]   m_busreq,
   input  logic [MASTER_NUMBER-1:0]   m_hlock,
   input  logic [2*MASTER_NUMBER-1:0] m_htrans,
   input  logic [3*MASTER_NUMBER-1:0] m_hburst,
   input  logic [32*MASTER_NUMBER-1:0] m_haddr,
   input  logic [MASTER_NUMBER-1:0]   m_hwrite,
   input  logic [32*MASTER_NUMBER-1:0] m_hwdata,
   input  logic                       hready,
   output logic [MASTER_NUMBER-1:0]   hgrant,
   output logic [31:0]                s_haddr,
   output logic [1:0]                 s_htrans,
   output logic [2:0]                 s_hburst,
   output logic                       s_hwrite,
   output logic [31:0]                s_hwdata,
   output logic [3:0]                 s_hmaster,
   output logic                       s_hmastlock
);

   localparam int IW = (MASTER_NUMBER > 1) ? $clog2(MASTER_NUMBER) : 1;

   logic [IW-1:0] grant_q;
   logic [IW-1:0] hmaster_q;
   logic [IW-1:0] dmaster_q;
   logic [4:0]    beats_q;
   logic          lock_q;

   logic [1:0]    htrans_a [MASTER_NUMBER];
   logic [2:0]    hburst_a [MASTER_NUMBER];
   logic [31:0]   haddr_a  [MASTER_NUMBER];
   logic [31:0]   hwdata_a [MASTER_NUMBER];

   logic [1:0]    own_htrans;
   logic [2:0]    own_hburst;
   logic [4:0]    beats_next;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] grant_next;
   logic          pick_any;
   logic          fixed_start;
   logic          lock_hold;
   logic          beats_ok;
   logic          arb_ok;

   // Unpack the per-master buses so the muxes can index by owner
   for (genvar i = 0; i < MASTER_NUMBER; i++) begin : g_unpack
      assign htrans_a[i] = m_htrans[2*i +: 2];
      assign hburst_a[i] = m_hburst[3*i +: 3];
      assign haddr_a[i]  = m_haddr[32*i +: 32];
      assign hwdata_a[i] = m_hwdata[32*i +: 32];
   end

   rr_pick #(
      .N  (MASTER_NUMBER),
      .IW (IW)
   ) u_rr_pick (
      .req     (m_busreq),
      .last    (grant_q),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   // Decide whether the grant may move this cycle. The grant holder keeps
   // the bus while it asserts hlock, which also covers the cycle before
   // lock_q has caught up with a freshly granted locking master. A burst
   // releases the grant on its last beat unless that beat is still BUSY.
   always_comb begin
      own_htrans  = htrans_a[hmaster_q];
      own_hburst  = hburst_a[hmaster_q];
      fixed_start = (own_htrans == NONSEQ) && (burst_beats(own_hburst) != 5'd0);
      lock_hold   = m_hlock[grant_q];
      beats_ok    = (beats_q == 5'd0) || ((beats_q == 5'd1) && (own_htrans != BUSY));
      arb_ok      = hready && !lock_hold && beats_ok && !fixed_start;
      grant_next  = pick_any ? pick_idx : '0;
   end

   // Track remaining beats of a fixed burst from the owner's transfer type
   always_comb begin
      beats_next = beats_q;
      case (own_htrans)
         NONSEQ:  beats_next = burst_beats(own_hburst);
         SEQ:     if (beats_q != 5'd0) beats_next = beats_q - 5'd1;
         IDLE:    beats_next = 5'd0;
         default: beats_next = beats_q;
      endcase
   end

   // Grant, ownership pipeline, burst counter and lock state
   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         grant_q   <= '0;
         hmaster_q <= '0;
         dmaster_q <= '0;
         beats_q   <= 5'd0;
         lock_q    <= 1'b0;
      end else begin
         if (arb_ok) begin
            grant_q <= grant_next;
         end
         if (hready) begin
            hmaster_q <= grant_q;
            dmaster_q <= hmaster_q;
            lock_q    <= m_hlock[grant_q];
            beats_q   <= beats_next;
         end
      end
   end

   // One-hot grant decode of the registered grant index
   always_comb begin
      hgrant = '0;
      for (int i = 0; i < MASTER_NUMBER; i++) begin
         hgrant[i] = (grant_q == IW'(i));
      end
   end

   // Slave-side muxes: address/control from the address-phase owner,
   // write data from the data-phase owner one accepted transfer behind
   always_comb begin
      s_haddr     = haddr_a[hmaster_q];
      s_htrans    = own_htrans;
      s_hburst    = own_hburst;
      s_hwrite    = m_hwrite[hmaster_q];
      s_hwdata    = hwdata_a[dmaster_q];
      s_hmaster   = 4'(hmaster_q);
      s_hmastlock = lock_q && (own_htrans != IDLE);
   end

endmodule
